wb_mem_responder: RTL and testbench
===================================

Name: wb_mem_responder

Overview:
- Wishbone classic responder: the slave end of the core_cyc/stb/we/sel/addr/data/ack bus that the processor wrapper drives as initiator.
- Owns a byte-enabled synchronous word RAM.
- Used as the simulation/FPGA instruction+data memory behind processorci_top, in place of the Controller memory.
- Wait states are configurable; out-of-range accesses are answered with an error instead of an ack.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0; must be 4-byte aligned.
- MEM_WORDS, 4096, RAM depth in 32-bit words; power of two, ≥ 16.
- WAIT_STATES, 0, extra cycles inserted before RAM access; range 0..15.
- INIT_FILE, "", hex file loaded with $readmemh at elaboration; empty means no load.

Ports:
- sys_clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_cyc_i  in  1  transaction active.
- wb_stb_i  in  1  request strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_sel_i  in  4  byte lane enables; bit i maps to data[8i+7:8i].
- wb_addr_i  in  32  byte address; bits [1:0] ignored.
- wb_dat_i  in  32  write data from initiator.
- wb_dat_o  out  32  read data to initiator.
- wb_ack_o  out  1  one-cycle successful completion.
- wb_err_o  out  1  one-cycle error completion (address out of range).
- busy_o  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (rst_n = 0, async):
  - state = IDLE; wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0, busy_o = 0.
  - Wait counter and latched request registers = 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP, ERR.
- IDLE:
  - Acts on cyc & stb. Latches addr, we, sel, dat.
  - Computes off = addr − BASE_ADDR.
  - If addr < BASE_ADDR or off ≥ MEM_WORDS*4 → out of range.
  - Next state: WAIT if WAIT_STATES > 0; else ACCESS.
  - An out-of-range request follows the same wait path but never touches RAM.
- WAIT: counts WAIT_STATES cycles (counter loaded with WAIT_STATES−1, decrements to 0), then → ACCESS.
- ACCESS: one cycle.
  - In range: RAM enable = 1. Write updates only lanes with sel = 1 at the end of this cycle; read data is registered into RAM output. → RESP.
  - Out of range: no RAM enable → ERR.
- RESP: wb_ack_o = 1 for exactly one cycle. wb_dat_o = RAM word for reads, 0 for writes. → IDLE.
- ERR: wb_err_o = 1 for exactly one cycle, wb_dat_o = 0. → IDLE.
- Outside RESP/ERR, wb_dat_o = 0. ack and err are never high together.
- Latency: request first seen in IDLE at cycle T → ack/err at cycle T+2+WAIT_STATES.
- Back-to-back: IDLE samples again the cycle after RESP/ERR. Throughput is one transfer per WAIT_STATES+3 cycles.
- Each IDLE acceptance produces exactly one ack/err, even with cyc/stb held permanently high (the initiator ties them to 1).
- Abort: cyc = 0 during WAIT or ACCESS → IDLE next cycle, no RAM write, no ack/err. RESP/ERR, once entered, always complete.
- Inputs are sampled only in IDLE. Changes to addr/dat/sel/we after acceptance have no effect on the current transfer.
- sel = 4'b0000 write: acked, RAM unchanged.
- Word index = off[log2(MEM_WORDS)+1:2]. No wrap-around: addresses past the top of RAM are errors, never aliased.
- Reset asserted mid-transfer: immediate IDLE, outputs 0. A write not yet past its ACCESS edge is not committed.

Decomposition:
- Package wb_resp_pkg holds:
  - the state enum: IDLE, WAIT, ACCESS, RESP, ERR;
  - WB_DATA_W = 32, WB_ADDR_W = 32, WB_SEL_W = 4;
  - function in_range(addr, base, words).
- One sub-module, wb_resp_ram: single-port MEM_WORDS×32 synchronous RAM with 4 byte write enables, registered read, and INIT_FILE load.
- FSM, counter and response muxing stay in wb_mem_responder.

Test Plan:
- Write then read, WAIT_STATES=0: write 32'hDEADBEEF to 0x10, sel=4'hF → ack at T+2; read 0x10 → ack at T+2, wb_dat_o = 32'hDEADBEEF, dat_o = 0 the cycle before and after.
- Byte lanes: word 0x20 = 32'h11223344, write 32'hAABBCCDD with sel=4'b0101 → readback 32'h11BB33DD. sel=0 write → ack, word unchanged.
- Wait states, WAIT_STATES=3: read with cyc/stb held high continuously → ack at T+5 and exactly one ack per 6 cycles; busy_o high for 5 of every 6 cycles.
- Out of range, MEM_WORDS=4096, BASE=0: read 0x4000 → err at T+2, ack = 0, dat_o = 0. Write 0x4000 then read 0x0000 → word 0 unchanged.
- Abort, WAIT_STATES=4: write 32'h12345678 to 0x8, drop cyc in the second WAIT cycle → no ack/err, IDLE next cycle; later read 0x8 returns the old value.
- Reset mid-transfer: rst_n low during ACCESS of a read → ack/err/dat_o/busy_o = 0 within the same cycle (async); after release, first new read acks at T+2 normally.

Source files
------------

// File: rtl/wb_resp_pkg.sv
// Shared types, bus widths and address decode helper for the Wishbone memory responder.
package wb_resp_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_SEL_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP,
        ERR
    } state_e;

    // Request captured at acceptance; oor marks an address outside the RAM window.
    typedef struct packed {
        logic                 oor;
        logic                 we;
        logic [WB_SEL_W-1:0]  sel;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] dat;
    } req_t;

    // True when addr falls inside [base, base + words*4); no wrap-around aliasing.
    function automatic logic in_range(input logic [WB_ADDR_W-1:0] addr,
                                      input logic [WB_ADDR_W-1:0] base,
                                      input int unsigned          words);
        logic [WB_ADDR_W-1:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> 2) < WB_ADDR_W'(words));
    endfunction

endpackage

// File: rtl/wb_mem_responder_if.sv
// Wishbone classic bus between the processor-side initiator and the memory responder.
interface wb_mem_responder_if;
    import wb_resp_pkg::*;

    logic                 wb_cyc_i;
    logic                 wb_stb_i;
    logic                 wb_we_i;
    logic [WB_SEL_W-1:0]  wb_sel_i;
    logic [WB_ADDR_W-1:0] wb_addr_i;
    logic [WB_DATA_W-1:0] wb_dat_i;
    logic [WB_DATA_W-1:0] wb_dat_o;
    logic                 wb_ack_o;
    logic                 wb_err_o;
    logic                 busy_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_addr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, busy_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_addr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o, busy_o
    );

endinterface

// File: rtl/wb_resp_ram.sv
// Single-port byte-enabled word RAM; read data is registered and reads as zero
// on any cycle that was not a read access, so it can drive the bus directly.
module wb_resp_ram
    import wb_resp_pkg::*;
#(
    parameter int unsigned WORDS     = 4096,
    parameter string       INIT_FILE = "",
    localparam int unsigned AW       = $clog2(WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 we,
    input  logic [WB_SEL_W-1:0]  sel,
    input  logic [AW-1:0]        addr,
    input  logic [WB_DATA_W-1:0] wdata,
    output logic [WB_DATA_W-1:0] rdata
);

    logic [WB_DATA_W-1:0] mem [WORDS];

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < int'(WB_SEL_W); i++) begin
                if (sel[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          rdata <= '0;
        else if (en && !we)  rdata <= mem[addr];
        else                 rdata <= '0;
    end

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone classic slave in front of a byte-enabled RAM with configurable wait
// states; out-of-window accesses complete with err instead of ack.
module wb_mem_responder
    import wb_resp_pkg::*;
#(
    parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned          MEM_WORDS   = 4096,
    parameter int unsigned          WAIT_STATES = 0,
    parameter string                INIT_FILE   = ""
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    wb_mem_responder_if.slave bus
);

    localparam int unsigned      AW        = $clog2(MEM_WORDS);
    localparam int unsigned      CNT_W     = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    req_t                 req_q;
    logic                 accept_c;
    logic                 ram_en_c;
    logic                 ack_q, err_q, busy_q;
    logic [AW-1:0]        ram_idx;
    logic [WB_DATA_W-1:0] ram_rdata;

    // Next-state logic; dropping cyc before RESP/ERR abandons the transfer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        ram_en_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.wb_cyc_i && bus.wb_stb_i) begin
                    accept_c = 1'b1;
                    if (WAIT_STATES != 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (!bus.wb_cyc_i)       state_d = IDLE;
                else if (cnt_q == '0)    state_d = ACCESS;
                else                     cnt_d   = cnt_q - CNT_W'(1);
            end
            ACCESS: begin
                if (!bus.wb_cyc_i) begin
                    state_d = IDLE;
                end else if (req_q.oor) begin
                    state_d = ERR;
                end else begin
                    ram_en_c = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State, counter, captured request and registered completion flags.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_c) begin
                req_q.oor  <= !in_range(bus.wb_addr_i, BASE_ADDR, MEM_WORDS);
                req_q.we   <= bus.wb_we_i;
                req_q.sel  <= bus.wb_sel_i;
                req_q.addr <= bus.wb_addr_i;
                req_q.dat  <= bus.wb_dat_i;
            end
            ack_q  <= (state_d == RESP);
            err_q  <= (state_d == ERR);
            busy_q <= (state_d != IDLE);
        end
    end

    assign ram_idx = AW'((req_q.addr - BASE_ADDR) >> 2);

    wb_resp_ram #(
        .WORDS     (MEM_WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .en    (ram_en_c),
        .we    (req_q.we),
        .sel   (req_q.sel),
        .addr  (ram_idx),
        .wdata (req_q.dat),
        .rdata (ram_rdata)
    );

    assign bus.wb_dat_o = ram_rdata;
    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;
    assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder at 0, 3 and 4 wait states sharing one stimulus stream.
module tb_wb_mem_responder;
    import wb_resp_pkg::*;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    int unsigned total   = 0;
    int unsigned passed  = 0;
    int unsigned failed  = 0;
    int unsigned acks;
    int unsigned busys;

    always #5 sys_clk = ~sys_clk;

    wb_mem_responder_if bus0 ();
    wb_mem_responder_if bus3 ();
    wb_mem_responder_if bus4 ();

    wb_mem_responder #(.BASE_ADDR(32'h0), .MEM_WORDS(4096), .WAIT_STATES(0), .INIT_FILE("")) u_ws0 (
        .sys_clk (sys_clk), .rst_n (rst_n), .bus (bus0));
    wb_mem_responder #(.BASE_ADDR(32'h0), .MEM_WORDS(4096), .WAIT_STATES(3), .INIT_FILE("")) u_ws3 (
        .sys_clk (sys_clk), .rst_n (rst_n), .bus (bus3));
    wb_mem_responder #(.BASE_ADDR(32'h0), .MEM_WORDS(4096), .WAIT_STATES(4), .INIT_FILE("")) u_ws4 (
        .sys_clk (sys_clk), .rst_n (rst_n), .bus (bus4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic drive(input logic c, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] dat);
        bus0.wb_cyc_i = c; bus0.wb_stb_i = c; bus0.wb_we_i = we;
        bus0.wb_sel_i = sel; bus0.wb_addr_i = addr; bus0.wb_dat_i = dat;
        bus3.wb_cyc_i = c; bus3.wb_stb_i = c; bus3.wb_we_i = we;
        bus3.wb_sel_i = sel; bus3.wb_addr_i = addr; bus3.wb_dat_i = dat;
        bus4.wb_cyc_i = c; bus4.wb_stb_i = c; bus4.wb_we_i = we;
        bus4.wb_sel_i = sel; bus4.wb_addr_i = addr; bus4.wb_dat_i = dat;
    endtask

    task automatic xfer(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] dat, input int lat);
        drive(1'b1, we, sel, addr, dat);
        tick(lat);
    endtask

    // One idle cycle returns every instance to IDLE (abort or completion).
    task automatic release_bus();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(2);
        chk("rst_ack",  32'(bus0.wb_ack_o), 32'h0);
        chk("rst_err",  32'(bus0.wb_err_o), 32'h0);
        chk("rst_dat",  bus0.wb_dat_o,      32'h0);
        chk("rst_busy", 32'(bus4.busy_o),   32'h0);
        rst_n = 1'b1;
        tick(1);

        // Zero wait states: write then read with exact latency.
        xfer(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1);
        chk("wr_t1_ack",  32'(bus0.wb_ack_o), 32'h0);
        chk("wr_t1_busy", 32'(bus0.busy_o),   32'h1);
        tick(1);
        chk("wr_t2_ack", 32'(bus0.wb_ack_o), 32'h1);
        chk("wr_t2_err", 32'(bus0.wb_err_o), 32'h0);
        chk("wr_t2_dat", bus0.wb_dat_o,      32'h0);
        release_bus();
        chk("wr_t3_ack",  32'(bus0.wb_ack_o), 32'h0);
        chk("wr_t3_busy", 32'(bus0.busy_o),   32'h0);

        xfer(1'b0, 4'hF, 32'h10, 32'h0, 1);
        chk("rd_t1_dat", bus0.wb_dat_o,      32'h0);
        chk("rd_t1_ack", 32'(bus0.wb_ack_o), 32'h0);
        tick(1);
        chk("rd_t2_ack", 32'(bus0.wb_ack_o), 32'h1);
        chk("rd_t2_dat", bus0.wb_dat_o,      32'hDEADBEEF);
        release_bus();
        chk("rd_t3_dat", bus0.wb_dat_o,      32'h0);
        chk("rd_t3_ack", 32'(bus0.wb_ack_o), 32'h0);

        // Byte lanes and the empty-select write.
        xfer(1'b1, 4'hF, 32'h20, 32'h11223344, 2);
        chk("lane_init_ack", 32'(bus0.wb_ack_o), 32'h1);
        release_bus();
        xfer(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 2);
        chk("lane_wr_ack", 32'(bus0.wb_ack_o), 32'h1);
        release_bus();
        xfer(1'b0, 4'hF, 32'h20, 32'h0, 2);
        chk("lane_rd_dat", bus0.wb_dat_o, 32'h11BB33DD);
        release_bus();
        xfer(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 2);
        chk("sel0_ack", 32'(bus0.wb_ack_o), 32'h1);
        release_bus();
        xfer(1'b0, 4'hF, 32'h20, 32'h0, 2);
        chk("sel0_rd_dat", bus0.wb_dat_o, 32'h11BB33DD);
        release_bus();

        // Address window: first word past the top errors, last word works.
        xfer(1'b1, 4'hF, 32'h0, 32'h0BADF00D, 2);
        chk("w0_ack", 32'(bus0.wb_ack_o), 32'h1);
        release_bus();
        xfer(1'b0, 4'hF, 32'h4000, 32'h0, 1);
        chk("oor_t1_err", 32'(bus0.wb_err_o), 32'h0);
        tick(1);
        chk("oor_rd_err", 32'(bus0.wb_err_o), 32'h1);
        chk("oor_rd_ack", 32'(bus0.wb_ack_o), 32'h0);
        chk("oor_rd_dat", bus0.wb_dat_o,      32'h0);
        release_bus();
        chk("oor_after_err", 32'(bus0.wb_err_o), 32'h0);
        xfer(1'b1, 4'hF, 32'h4000, 32'hCAFEF00D, 2);
        chk("oor_wr_err", 32'(bus0.wb_err_o), 32'h1);
        release_bus();
        xfer(1'b0, 4'hF, 32'h0, 32'h0, 2);
        chk("w0_rd_ack", 32'(bus0.wb_ack_o), 32'h1);
        chk("w0_rd_dat", bus0.wb_dat_o,      32'h0BADF00D);
        release_bus();
        xfer(1'b1, 4'hF, 32'h3FFC, 32'h55AA55AA, 2);
        chk("top_wr_ack", 32'(bus0.wb_ack_o), 32'h1);
        chk("top_wr_err", 32'(bus0.wb_err_o), 32'h0);
        release_bus();
        xfer(1'b0, 4'hF, 32'h3FFC, 32'h0, 2);
        chk("top_rd_dat", bus0.wb_dat_o, 32'h55AA55AA);
        release_bus();

        // Three wait states with cyc/stb held: one ack every six cycles.
        xfer(1'b1, 4'hF, 32'h30, 32'h13572468, 5);
        chk("ws3_wr_ack", 32'(bus3.wb_ack_o), 32'h1);
        release_bus();
        drive(1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
        acks  = 0;
        busys = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            chk($sformatf("ws3_ack_c%0d", k), 32'(bus3.wb_ack_o), (k % 6 == 5) ? 32'h1 : 32'h0);
            chk($sformatf("ws3_dat_c%0d", k), bus3.wb_dat_o, (k % 6 == 5) ? 32'h13572468 : 32'h0);
            acks  += int'(bus3.wb_ack_o);
            busys += int'(bus3.busy_o);
        end
        chk("ws3_ack_count",  acks,  32'd2);
        chk("ws3_busy_count", busys, 32'd10);
        release_bus();

        // Four wait states: late input changes ignored, then an aborted write.
        xfer(1'b1, 4'hF, 32'h8, 32'h00000A0A, 1);
        drive(1'b1, 1'b1, 4'h0, 32'h8, 32'hFFFFFFFF);
        tick(5);
        chk("ws4_wr_ack", 32'(bus4.wb_ack_o), 32'h1);
        release_bus();
        xfer(1'b1, 4'hF, 32'h8, 32'h12345678, 2);
        chk("abort_busy_wait", 32'(bus4.busy_o), 32'h1);
        release_bus();
        chk("abort_busy_idle", 32'(bus4.busy_o),   32'h0);
        chk("abort_ack",       32'(bus4.wb_ack_o), 32'h0);
        chk("abort_err",       32'(bus4.wb_err_o), 32'h0);
        tick(6);
        chk("abort_late_ack", 32'(bus4.wb_ack_o), 32'h0);
        xfer(1'b0, 4'hF, 32'h8, 32'h0, 6);
        chk("abort_rd_ack", 32'(bus4.wb_ack_o), 32'h1);
        chk("abort_rd_dat", bus4.wb_dat_o,      32'h00000A0A);
        release_bus();

        // Asynchronous reset while a read is in ACCESS.
        xfer(1'b0, 4'hF, 32'h10, 32'h0, 1);
        chk("mid_busy_pre", 32'(bus0.busy_o), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(bus0.busy_o),   32'h0);
        chk("mid_rst_ack",   32'(bus0.wb_ack_o), 32'h0);
        chk("mid_rst_err",   32'(bus0.wb_err_o), 32'h0);
        chk("mid_rst_dat",   bus0.wb_dat_o,      32'h0);
        chk("mid_rst_busy3", 32'(bus3.busy_o),   32'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_ack", 32'(bus0.wb_ack_o), 32'h0);
        xfer(1'b0, 4'hF, 32'h10, 32'h0, 1);
        chk("post_rst_t1_ack", 32'(bus0.wb_ack_o), 32'h0);
        tick(1);
        chk("post_rst_t2_ack", 32'(bus0.wb_ack_o), 32'h1);
        chk("post_rst_t2_dat", bus0.wb_dat_o,      32'hDEADBEEF);
        release_bus();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
